// File: rtl/dmem_ctrl.sv
// dmem_ctrl: core data-side controller serving a byte-enabled RAM and an MMIO page (GPIO, optional timer/IRQ).
// The optional timer (COUNT/CMP/STATUS and IRQ) is built only when DMEM_TIMER_EN is defined.
module dmem_ctrl #(
    parameter int DATAWIDTH  = 32,
    parameter int RAM_AWIDTH = 10,
    parameter int GPIO_WIDTH = 8
) (
    input  logic                  DMEM_Clk_in,
    input  logic                  DMEM_Reset_in,
    input  logic                  DMEM_Read_in,
    input  logic                  DMEM_Write_in,
    input  logic [3:0]            DMEM_Byteenable_InBUS,
    input  logic [DATAWIDTH-1:0]  DMEM_Addr_InBUS,
    input  logic [DATAWIDTH-1:0]  DMEM_Writedata_InBUS,
    output logic [DATAWIDTH-1:0]  DMEM_Readdata_OutBUS,
    output logic [GPIO_WIDTH-1:0] DMEM_Gpio_OutBUS,
    output logic                  DMEM_Irq_out
);

    // Replace only the enabled byte lanes of an existing word.
    function automatic logic [DATAWIDTH-1:0] f_merge(input logic [DATAWIDTH-1:0] old_v,
                                                     input logic [DATAWIDTH-1:0] new_v,
                                                     input logic [3:0] be);
        logic [DATAWIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++)
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        return res;
    endfunction

    logic [DATAWIDTH-1:0]  r_ram [0:2**RAM_AWIDTH-1];
    logic [GPIO_WIDTH-1:0] r_gpio;
    logic [RAM_AWIDTH-1:0] w_idx;
    logic [1:0]            w_off;
    logic                  w_ram_sel;
    logic                  w_mmio_sel;
    logic                  w_mmio_wr;
    logic [DATAWIDTH-1:0]  w_gpio_ext;
    logic [DATAWIDTH-1:0]  w_gpio_next;
    logic [DATAWIDTH-1:0]  w_mmio_rdata;
    logic                  w_unused;

    assign w_idx      = DMEM_Addr_InBUS[RAM_AWIDTH+1:2];
    assign w_off      = DMEM_Addr_InBUS[3:2];
    assign w_ram_sel  = ~DMEM_Addr_InBUS[DATAWIDTH-1];
    assign w_mmio_sel = DMEM_Addr_InBUS[DATAWIDTH-1] && (DMEM_Addr_InBUS[DATAWIDTH-2:4] == '0);
    assign w_mmio_wr  = DMEM_Write_in && w_mmio_sel;
    assign w_gpio_ext  = DATAWIDTH'(r_gpio);
    assign w_gpio_next = f_merge(w_gpio_ext, DMEM_Writedata_InBUS, DMEM_Byteenable_InBUS);
    // Byte offset bits and GPIO lanes above GPIO_WIDTH are intentionally dropped.
    assign w_unused    = ^{DMEM_Addr_InBUS[1:0], w_gpio_next};

    // RAM store: byte-lane write, no reset; a store seen while reset is held is dropped.
    always_ff @(posedge DMEM_Clk_in) begin
        if (DMEM_Reset_in && DMEM_Write_in && w_ram_sel)
            for (int b = 0; b < 4; b++)
                if (DMEM_Byteenable_InBUS[b]) r_ram[w_idx][8*b +: 8] <= DMEM_Writedata_InBUS[8*b +: 8];
    end

    // GPIO output register.
    always_ff @(posedge DMEM_Clk_in or negedge DMEM_Reset_in) begin
        if (!DMEM_Reset_in)
            r_gpio <= '0;
        else if (w_mmio_wr && w_off == 2'd0)
            r_gpio <= w_gpio_next[GPIO_WIDTH-1:0];
    end

    assign DMEM_Gpio_OutBUS = r_gpio;

`ifdef DMEM_TIMER_EN
    logic [DATAWIDTH-1:0] r_count;
    logic [DATAWIDTH-1:0] r_cmp;
    logic                 r_ten;
    logic                 r_match;
    logic                 w_wr_count;
    logic                 w_wr_cmp;
    logic                 w_wr_stat;
    logic                 w_clr;

    assign w_wr_count = w_mmio_wr && w_off == 2'd1;
    assign w_wr_cmp   = w_mmio_wr && w_off == 2'd2;
    assign w_wr_stat  = w_mmio_wr && w_off == 2'd3 && DMEM_Byteenable_InBUS[0];
    assign w_clr      = w_wr_stat && DMEM_Writedata_InBUS[0];

    // Timer: software COUNT write beats the increment; a MATCH set beats a W1C clear.
    always_ff @(posedge DMEM_Clk_in or negedge DMEM_Reset_in) begin
        if (!DMEM_Reset_in) begin
            r_count <= '0;
            r_cmp   <= '1;
            r_ten   <= 1'b0;
            r_match <= 1'b0;
        end else begin
            if (w_wr_count)
                r_count <= f_merge(r_count, DMEM_Writedata_InBUS, DMEM_Byteenable_InBUS);
            else if (r_ten)
                r_count <= r_count + 1'b1;
            if (w_wr_cmp)
                r_cmp <= f_merge(r_cmp, DMEM_Writedata_InBUS, DMEM_Byteenable_InBUS);
            if (w_wr_stat)
                r_ten <= DMEM_Writedata_InBUS[1];
            r_match <= (r_ten && r_count == r_cmp) || (r_match && !w_clr);
        end
    end

    assign DMEM_Irq_out = r_match;
    assign w_mmio_rdata = (w_off == 2'd0) ? w_gpio_ext :
                          (w_off == 2'd1) ? r_count :
                          (w_off == 2'd2) ? r_cmp :
                                            {{(DATAWIDTH-2){1'b0}}, r_ten, r_match};
`else
    assign DMEM_Irq_out = 1'b0;
    assign w_mmio_rdata = (w_off == 2'd0) ? w_gpio_ext : '0;
`endif

    assign DMEM_Readdata_OutBUS = !DMEM_Read_in ? '0 :
                                  w_ram_sel     ? r_ram[w_idx] :
                                  w_mmio_sel    ? w_mmio_rdata : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl (timer checks follow DMEM_TIMER_EN).
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [7:0]  gpio;
    logic        irq;
    logic [31:0] v;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DATAWIDTH(32), .RAM_AWIDTH(10), .GPIO_WIDTH(8)) dut (
        .DMEM_Clk_in(clk),
        .DMEM_Reset_in(rst_n),
        .DMEM_Read_in(rd),
        .DMEM_Write_in(wr),
        .DMEM_Byteenable_InBUS(be),
        .DMEM_Addr_InBUS(addr),
        .DMEM_Writedata_InBUS(wdata),
        .DMEM_Readdata_OutBUS(rdata),
        .DMEM_Gpio_OutBUS(gpio),
        .DMEM_Irq_out(irq)
    );

    // Store occupying exactly one rising edge; returns 1 ns after that edge.
    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; wr = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0; be = 4'h0;
    endtask

    // Combinational load, no clock edge consumed.
    task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        #1 d = rdata;
        rd = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (gpio !== 8'h00) begin n_err++; $display("FAIL reset_gpio: got %h want 00", gpio); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
        rd_reg(32'h8000_0008, v);
`ifdef DMEM_TIMER_EN
        n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_cmp: got %h want ffffffff", v); end
`else
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_cmp_off: got %h want 0", v); end
`endif
        rd_reg(32'h8000_000C, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h want 0", v); end
    endtask

    task automatic test_ram;
        wr_reg(32'h0000_0010, 32'h1122_3344, 4'b1111);
        wr_reg(32'h0000_0010, 32'hAABB_CCDD, 4'b0101);
        rd_reg(32'h0000_0010, v);
        n_cmp++; if (v !== 32'h11BB_33DD) begin n_err++; $display("FAIL ram_be: got %h want 11bb33dd", v); end
        rd_reg(32'h0000_1010, v);
        n_cmp++; if (v !== 32'h11BB_33DD) begin n_err++; $display("FAIL ram_alias: got %h want 11bb33dd", v); end
        addr = 32'h0000_0010; rd = 1'b0;
        #1;
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL ram_noread: got %h want 0", rdata); end
    endtask

    task automatic test_read_during_write;
        addr = 32'h0000_0010; wdata = 32'h5555_0000; be = 4'b1111; rd = 1'b1; wr = 1'b1;
        #1;
        n_cmp++; if (rdata !== 32'h11BB_33DD) begin n_err++; $display("FAIL rw_prewrite: got %h want 11bb33dd", rdata); end
        @(posedge clk); #1;
        wr = 1'b0; be = 4'h0;
        #1;
        n_cmp++; if (rdata !== 32'h5555_0000) begin n_err++; $display("FAIL rw_postwrite: got %h want 55550000", rdata); end
        rd = 1'b0;
    endtask

    task automatic test_gpio;
        wr_reg(32'h8000_0000, 32'h0000_00A5, 4'b0001);
        n_cmp++; if (gpio !== 8'hA5) begin n_err++; $display("FAIL gpio_write: got %h want a5", gpio); end
        wr_reg(32'h8000_0000, 32'h0000_FF00, 4'b0010);
        n_cmp++; if (gpio !== 8'hA5) begin n_err++; $display("FAIL gpio_lane1: got %h want a5", gpio); end
        rd_reg(32'h8000_0000, v);
        n_cmp++; if (v !== 32'h0000_00A5) begin n_err++; $display("FAIL gpio_read: got %h want 000000a5", v); end
        wr_reg(32'h8000_0040, 32'h1234_5678, 4'b1111);
        rd_reg(32'h8000_0040, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL unmapped: got %h want 0", v); end
        n_cmp++; if (gpio !== 8'hA5) begin n_err++; $display("FAIL unmapped_gpio: got %h want a5", gpio); end
    endtask

`ifdef DMEM_TIMER_EN
    task automatic test_timer;
        wr_reg(32'h8000_0008, 32'd5, 4'b1111);
        wr_reg(32'h8000_000C, 32'h2, 4'b1111);
        rd_reg(32'h8000_0004, v);
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL timer_start: got %h want 0", v); end
        repeat (5) @(posedge clk);
        #1;
        rd_reg(32'h8000_0004, v);
        n_cmp++; if (v !== 32'd5) begin n_err++; $display("FAIL timer_count5: got %h want 5", v); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL timer_irq_early: got %b want 0", irq); end
        @(posedge clk); #1;
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL timer_irq_rise: got %b want 1", irq); end
        rd_reg(32'h8000_000C, v);
        n_cmp++; if (v !== 32'h3) begin n_err++; $display("FAIL timer_status: got %h want 3", v); end
        wr_reg(32'h8000_000C, 32'h1, 4'b0001);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL timer_w1c: got %b want 0", irq); end
        rd_reg(32'h8000_000C, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL timer_status_clr: got %h want 0", v); end
    endtask

    task automatic test_wrap;
        wr_reg(32'h8000_0004, 32'hFFFF_FFFF, 4'b1111);
        wr_reg(32'h8000_000C, 32'h2, 4'b1111);
        rd_reg(32'h8000_0004, v);
        n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_pre: got %h want ffffffff", v); end
        @(posedge clk); #1;
        rd_reg(32'h8000_0004, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL wrap_zero: got %h want 0", v); end
        wr_reg(32'h8000_0004, 32'd7, 4'b1111);
        rd_reg(32'h8000_0004, v);
        n_cmp++; if (v !== 32'd7) begin n_err++; $display("FAIL wr_prio: got %h want 7", v); end
        @(posedge clk); #1;
        rd_reg(32'h8000_0004, v);
        n_cmp++; if (v !== 32'd8) begin n_err++; $display("FAIL wr_then_inc: got %h want 8", v); end
        wr_reg(32'h8000_0004, 32'h0000_AB00, 4'b0010);
        rd_reg(32'h8000_0004, v);
        n_cmp++; if (v !== 32'h0000_AB08) begin n_err++; $display("FAIL wr_partial: got %h want 0000ab08", v); end
    endtask
`else
    task automatic test_timer_off;
        wr_reg(32'h8000_0004, 32'h1234_5678, 4'b1111);
        wr_reg(32'h8000_0008, 32'h0, 4'b1111);
        wr_reg(32'h8000_000C, 32'h3, 4'b1111);
        repeat (3) @(posedge clk);
        #1;
        rd_reg(32'h8000_0004, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL off_count: got %h want 0", v); end
        rd_reg(32'h8000_0008, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL off_cmp: got %h want 0", v); end
        rd_reg(32'h8000_000C, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL off_status: got %h want 0", v); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL off_irq: got %b want 0", irq); end
    endtask
`endif

    task automatic test_async_reset;
`ifdef DMEM_TIMER_EN
        wr_reg(32'h8000_0008, 32'h0, 4'b1111);
        wr_reg(32'h8000_0004, 32'h0, 4'b1111);
        @(posedge clk); #1;
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL ar_irq_pre: got %b want 1", irq); end
`endif
        addr = 32'h8000_0000; wdata = 32'h0000_00FF; be = 4'b1111; wr = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (gpio !== 8'h00) begin n_err++; $display("FAIL ar_gpio: got %h want 00", gpio); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ar_irq: got %b want 0", irq); end
        rd_reg(32'h8000_0004, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL ar_count: got %h want 0", v); end
        rd_reg(32'h8000_0008, v);
`ifdef DMEM_TIMER_EN
        n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ar_cmp: got %h want ffffffff", v); end
`else
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL ar_cmp_off: got %h want 0", v); end
`endif
        @(posedge clk); #1;
        n_cmp++; if (gpio !== 8'h00) begin n_err++; $display("FAIL ar_hold: got %h want 00", gpio); end
        wr = 1'b0; be = 4'h0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (gpio !== 8'h00) begin n_err++; $display("FAIL ar_lost: got %h want 00", gpio); end
        rd_reg(32'h8000_000C, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL ar_status: got %h want 0", v); end
    endtask

    initial begin
        test_reset;
        test_ram;
        test_read_during_write;
        test_gpio;
`ifdef DMEM_TIMER_EN
        test_timer;
        test_wrap;
`else
        test_timer_off;
`endif
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 ns");
        $fatal(1);
    end
endmodule
